dsp_mac_pipe: RTL
=================

DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  A_W, 18, width of multiplier operand a
  B_W, 18, width of pre-adder operands b and d
  C_W, 48, width of post-adder operand c
  P_W, 48, width of result p; SHALL satisfy P_W >= A_W+B_W+1 and P_W >= C_W
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk        input   1      clock, rising edge
  rst_n      input   1      asynchronous active-low reset
  ce         input   1      pipeline clock enable; 0 freezes every register
  in_valid   input   1      operand set valid this cycle
  a          input   A_W    signed multiplier operand
  b          input   B_W    signed pre-adder operand
  d          input   B_W    signed pre-adder operand
  c          input   C_W    signed post-adder operand
  opmode     input   3      [0] pre-sub (d-b), [1] post-sub, [2] accumulate
  acc_clr    input   1      start a new accumulation with this operand set
  out_valid  output  1      p holds a new result
  p          output  P_W    signed result
  ovf        output  1      signed overflow on the result presented with out_valid
REQ-003 Reset SHALL be rst_n, asynchronous, active-low; clock SHALL be clk.

Function
REQ-004 All arithmetic SHALL be two's-complement signed; every operand SHALL be sign-extended before use.
REQ-005 Stage 1 SHALL register a, b, d, c, opmode, acc_clr and in_valid when ce=1.
REQ-006 Stage 2 SHALL compute pre = d+b (opmode[0]=0) or d-b (opmode[0]=1) at width B_W+1 with no truncation, and SHALL delay a, c and the control bits by one stage.
REQ-007 Stage 3 SHALL compute m = a*pre at width A_W+B_W+1, then sign-extend m to P_W.
REQ-008 Stage 4 SHALL select the addend: c sign-extended (opmode[2]=0); current p (opmode[2]=1, acc_clr=0); or zero (opmode[2]=1, acc_clr=1).
REQ-009 Stage 4 SHALL produce addend+m (opmode[1]=0) or addend-m (opmode[1]=1), modulo 2^P_W.
REQ-010 Latency SHALL be exactly 4 enabled clk edges: an operand set accepted with in_valid=1 at edge N appears on p with out_valid=1 after edge N+3, given ce=1 throughout.
REQ-011 Valid SHALL propagate through a 4-deep shift register alongside the data; bubbles (in_valid=0) SHALL propagate as bubbles.
REQ-012 p and ovf SHALL update only when the stage-4 valid is 1 and ce=1; otherwise both SHALL hold their values.
REQ-013 out_valid SHALL be high for exactly one enabled cycle per accepted operand set.
REQ-014 When ce=0, all stage registers, out_valid, p and ovf SHALL hold; no operand set SHALL be lost or duplicated.
REQ-015 ovf SHALL be 1 when the true P_W+1-bit signed result of stage 4 differs from the wrapped p, and 0 otherwise; it SHALL be re-evaluated for each result and SHALL NOT be sticky.
REQ-016 acc_clr with opmode[2]=0 SHALL have no effect.
REQ-017 Back-to-back accumulate operands SHALL each see the p produced by the immediately preceding valid result; no forwarding hazard SHALL exist.
REQ-018 Throughput SHALL be one operand set per enabled cycle.

Reset
REQ-019 While rst_n=0, every pipeline register SHALL clear to 0, and out_valid=0, p=0, ovf=0.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight operand sets; the first out_valid after release SHALL correspond to the first operand set accepted after release.
REQ-021 An accumulate without acc_clr as the first operation after reset SHALL use addend 0, because p resets to 0.

Verification
REQ-022 Scenario 1: a=3, b=4, d=10, c=100, opmode=000, single valid -> 4 cycles later out_valid=1, p=142, ovf=0; p holds afterwards.
REQ-023 Scenario 2: a=-2, b=5, d=1, c=7, opmode=011 -> p = 7-(-2*(1-5)) = -1.
REQ-024 Scenario 3: five consecutive valids, a=1, b=1, d=0, opmode=100, acc_clr=1 on the first only -> p steps 1,2,3,4,5 on consecutive cycles; a sixth valid with acc_clr=1 -> p=1.
REQ-025 Scenario 4: a=2, b=0, d=1 with in_valid=1, then ce=0 for 3 cycles at stage 2 -> out_valid is delayed exactly 3 cycles, and exactly one pulse occurs.
REQ-026 Scenario 5: c=2^(P_W-1)-1, a=1, b=0, d=1, opmode=000 -> p = -2^(P_W-1) (wrap), ovf=1 for that result; the next non-overflowing result clears ovf.
REQ-027 Scenario 6: three valids in flight, rst_n pulsed low asynchronously between edges -> outputs are 0 immediately, and no stale out_valid appears after release.

Source files
------------

// File: rtl/dsp_mac_pipe.sv
// Four-stage pre-add / multiply / post-add MAC pipeline with accumulate and overflow flag.
// Data and valid advance together under a single clock enable.
module dsp_mac_pipe #(
    parameter int A_W = 18,
    parameter int B_W = 18,
    parameter int C_W = 48,
    parameter int P_W = 48
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ce,
    input  logic           in_valid,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    input  logic [B_W-1:0] d,
    input  logic [C_W-1:0] c,
    input  logic [2:0]     opmode,
    input  logic           acc_clr,
    output logic           out_valid,
    output logic [P_W-1:0] p,
    output logic           ovf
);

    localparam int PRE_W = B_W + 1;
    localparam int M_W   = A_W + B_W + 1;
    localparam int S_W   = P_W + 1;

    function automatic logic signed [PRE_W-1:0] pre_add(
        input logic signed [B_W-1:0] dv,
        input logic signed [B_W-1:0] bv,
        input logic                  sub
    );
        logic signed [PRE_W-1:0] de;
        logic signed [PRE_W-1:0] be;
        de = PRE_W'(dv);
        be = PRE_W'(bv);
        return sub ? (de - be) : (de + be);
    endfunction

    function automatic logic signed [M_W-1:0] mul_full(
        input logic signed [A_W-1:0]   av,
        input logic signed [PRE_W-1:0] pv
    );
        return M_W'(av) * M_W'(pv);
    endfunction

    // The extra top bit of the unwrapped sum disagrees with the kept sign bit on overflow.
    function automatic logic wrap_ovf(input logic signed [S_W-1:0] s);
        return s[S_W-1] != s[S_W-2];
    endfunction

    logic signed [A_W-1:0]   a_p0, a_p1;
    logic signed [B_W-1:0]   b_p0, d_p0;
    logic signed [C_W-1:0]   c_p0, c_p1, c_p2;
    logic        [2:0]       op_p0;
    logic        [2:1]       op_p1, op_p2;
    logic                    clr_p0, clr_p1, clr_p2;
    logic                    vld_p0, vld_p1, vld_p2;
    logic signed [PRE_W-1:0] pre_p1;
    logic signed [M_W-1:0]   m_p2;

    logic signed [P_W-1:0]   addend;
    logic signed [S_W-1:0]   sum_full;

    // Accumulation reads p directly, so back-to-back accumulates need no forwarding.
    always_comb begin
        addend = P_W'(c_p2);
        if (op_p2[2]) begin
            addend = clr_p2 ? '0 : $signed(p);
        end
        if (op_p2[1]) begin
            sum_full = S_W'(addend) - S_W'(m_p2);
        end else begin
            sum_full = S_W'(addend) + S_W'(m_p2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p0      <= '0;
            b_p0      <= '0;
            d_p0      <= '0;
            c_p0      <= '0;
            op_p0     <= '0;
            clr_p0    <= 1'b0;
            vld_p0    <= 1'b0;
            a_p1      <= '0;
            c_p1      <= '0;
            pre_p1    <= '0;
            op_p1     <= '0;
            clr_p1    <= 1'b0;
            vld_p1    <= 1'b0;
            m_p2      <= '0;
            c_p2      <= '0;
            op_p2     <= '0;
            clr_p2    <= 1'b0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
            p         <= '0;
            ovf       <= 1'b0;
        end else if (ce) begin
            // stage 1: operand capture
            a_p0   <= a;
            b_p0   <= b;
            d_p0   <= d;
            c_p0   <= c;
            op_p0  <= opmode;
            clr_p0 <= acc_clr;
            vld_p0 <= in_valid;
            // stage 2: pre-adder
            a_p1   <= a_p0;
            c_p1   <= c_p0;
            pre_p1 <= pre_add(d_p0, b_p0, op_p0[0]);
            op_p1  <= op_p0[2:1];
            clr_p1 <= clr_p0;
            vld_p1 <= vld_p0;
            // stage 3: multiplier
            m_p2   <= mul_full(a_p1, pre_p1);
            c_p2   <= c_p1;
            op_p2  <= op_p1;
            clr_p2 <= clr_p1;
            vld_p2 <= vld_p1;
            // stage 4: post-adder / accumulator
            out_valid <= vld_p2;
            if (vld_p2) begin
                p   <= sum_full[P_W-1:0];
                ovf <= wrap_ovf(sum_full);
            end
        end
    end

endmodule
